anim_seq: RTL and testbench

ANIM_SEQ -- requirements
Module: anim_seq

---
 rtl/anim_seq.sv | 152 +++++++++++++++
 tb/tb_anim_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/anim_seq.sv
// ---------------------------------------------------------------------------
// anim_seq -- frame-by-frame LED animation sequencer.
//
// Steps a 7-bit frame address through a combinational frame ROM. For each
// frame it spends one LOAD cycle, in which the ROM pattern is captured into
// the LED register, and then period+1 SHOW cycles. Frames can play upward or
// downward, once or in an endless loop.
//
// Ports:
//   i_clk     system clock, all state changes on the rising edge
//   i_rst     synchronous active-high reset
//   i_start   start playback; only acted on in IDLE
//   i_stop    abort playback; wins over start and frame advance
//   i_dir     0 = ascending frames, 1 = descending (latched at start)
//   i_loop    1 = replay forever, 0 = play once (latched at start)
//   i_period  SHOW length minus one, in cycles (latched at start)
//   o_addr    registered frame index to the frame ROM
//   i_pat     active-low LED pattern from the ROM for o_addr, same cycle
//   o_led     registered active-low LED drive, 7'h7F = all off
//   o_busy    high in LOAD and SHOW
//   o_done    one-cycle pulse when a play-once run completes
// ---------------------------------------------------------------------------
module anim_seq #(
  parameter int FRAMES = 128,
  parameter int DIV_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_dir,
  input  logic             i_loop,
  input  logic [DIV_W-1:0] i_period,
  output logic [6:0]       o_addr,
  input  logic [6:0]       i_pat,
  output logic [6:0]       o_led,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [6:0] LAST    = 7'(FRAMES - 1);
  localparam logic [6:0] LED_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SHOW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [6:0]       r_addr, w_addr;
  logic [6:0]       r_led, w_led;
  logic [DIV_W-1:0] r_div, w_div;
  logic             r_dir, w_dir;
  logic             r_loop, w_loop;
  logic [DIV_W-1:0] r_period, w_period;

  // Last frame of the run depends on the latched direction.
  logic w_last;
  assign w_last = r_dir ? (r_addr == 7'd0) : (r_addr == LAST);

  always_comb begin
    w_state  = r_state;
    w_addr   = r_addr;
    w_led    = r_led;
    w_div    = r_div;
    w_dir    = r_dir;
    w_loop   = r_loop;
    w_period = r_period;

    case (r_state)
      S_IDLE: begin
        w_addr = 7'd0;
        if (i_start && !i_stop) begin
          w_state  = S_LOAD;
          w_addr   = i_dir ? LAST : 7'd0;
          w_dir    = i_dir;
          w_loop   = i_loop;
          w_period = i_period;
        end
      end
      S_LOAD: begin
        if (i_stop) begin
          w_state = S_IDLE;
          w_addr  = 7'd0;
          w_led   = LED_OFF;
        end else begin
          w_state = S_SHOW;
          w_led   = i_pat;
          w_div   = '0;
        end
      end
      S_SHOW: begin
        if (i_stop) begin
          w_state = S_IDLE;
          w_addr  = 7'd0;
          w_led   = LED_OFF;
        end else if (r_div == r_period) begin
          if (!w_last) begin
            w_state = S_LOAD;
            w_addr  = r_dir ? r_addr - 7'd1 : r_addr + 7'd1;
          end else if (r_loop) begin
            w_state = S_LOAD;
            w_addr  = r_dir ? LAST : 7'd0;
          end else begin
            w_state = S_DONE;
          end
        end else begin
          // Cannot wrap: the compare above catches r_div == r_period first.
          w_div = r_div + 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_addr  = 7'd0;
        if (i_stop) w_led = LED_OFF;
      end
      default: begin
        w_state = S_IDLE;
        w_addr  = 7'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_addr   <= 7'd0;
      r_led    <= LED_OFF;
      r_div    <= '0;
      r_dir    <= 1'b0;
      r_loop   <= 1'b0;
      r_period <= '0;
    end else begin
      r_state  <= w_state;
      r_addr   <= w_addr;
      r_led    <= w_led;
      r_div    <= w_div;
      r_dir    <= w_dir;
      r_loop   <= w_loop;
      r_period <= w_period;
    end
  end

  assign o_addr = r_addr;
  assign o_led  = r_led;
  assign o_busy = (r_state == S_LOAD) || (r_state == S_SHOW);
  // A stop landing in the DONE cycle suppresses the completion pulse.
  assign o_done = (r_state == S_DONE) && !i_stop;

endmodule

// File: tb/tb_anim_seq.sv
// ---------------------------------------------------------------------------
// tb_anim_seq -- self-checking bench for anim_seq.
// A table of runs (direction, loop, period, plus optional mid-run stop,
// reset, start pulse or control scrambling) is played back. For each cycle
// the expected outputs come from a closed-form timeline of the run and go
// into a scoreboard queue; they are popped and compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_anim_seq;

  logic        clk = 1'b0;
  logic        rst, start, stop, dir, loop;
  logic [15:0] period;
  logic [6:0]  addr, pat, led;
  logic        busy, done;

  always #5 clk = ~clk;

  function automatic logic [6:0] rom(input logic [6:0] a);
    return (a * 7'd37) ^ 7'h55;
  endfunction

  assign pat = rom(addr);

  anim_seq #(.FRAMES(128), .DIV_W(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_stop  (stop),
    .i_dir   (dir),
    .i_loop  (loop),
    .i_period(period),
    .o_addr  (addr),
    .i_pat   (pat),
    .o_led   (led),
    .o_busy  (busy),
    .o_done  (done)
  );

  typedef struct {
    int dir, loop, period, ncyc, stop_at, rst_at, start_at, mutate;
  } vec_t;

  typedef struct {
    logic [6:0] addr;
    logic [6:0] led;
    logic       busy;
    logic       done;
    logic       chk_addr;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cur_run = 0;
  int         cur_k   = 0;
  logic [6:0] led_prev;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] ex);
    n_tests++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s run=%0d k=%0d: got %h, expected %h", nm, cur_run, cur_k, act, ex);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty run=%0d k=%0d", cur_run, cur_k);
      return;
    end
    e = sb.pop_front();
    if (e.chk_addr) chk("addr", addr, e.addr);
    chk("led",  led,  e.led);
    chk("busy", {6'd0, busy}, {6'd0, e.busy});
    chk("done", {6'd0, done}, {6'd0, e.done});
  endtask

  function automatic logic [6:0] addr_of(input int dirv, input int idx);
    return dirv ? 7'(127 - idx) : 7'(idx);
  endfunction

  // Expected outputs k cycles after entering the first LOAD of a run.
  function automatic exp_t expect_at(input vec_t v, input int k, input logic [6:0] lp);
    exp_t e;
    int fl = v.period + 2;
    int d  = 128 * fl;
    int f  = k / fl;
    int ph = k % fl;
    e = '{addr: 7'd0, led: 7'h7F, busy: 1'b0, done: 1'b0, chk_addr: 1'b1};
    if ((v.stop_at >= 0 && k > v.stop_at) || (v.rst_at >= 0 && k > v.rst_at))
      return e;
    if (!v.loop && f >= 128) begin
      e.led = rom(addr_of(v.dir, 127));
      if (k == d) begin
        e.done = 1'b1;
        e.chk_addr = 1'b0;
      end
      return e;
    end
    e.addr = addr_of(v.dir, f % 128);
    e.busy = 1'b1;
    if (ph != 0)     e.led = rom(e.addr);
    else if (f == 0) e.led = lp;
    else             e.led = rom(addr_of(v.dir, (f - 1) % 128));
    return e;
  endfunction

  task automatic run(input vec_t v);
    exp_t e;
    dir = v.dir[0]; loop = v.loop[0]; period = 16'(v.period);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < v.ncyc; k++) begin
      cur_k = k;
      e = expect_at(v, k, led_prev);
      sb.push_back(e);
      if (v.mutate != 0) begin
        dir    = 1'($urandom_range(0, 1));
        loop   = 1'($urandom_range(0, 1));
        period = 16'($urandom_range(0, 65535));
      end
      if (k == v.stop_at)  stop  = 1'b1;
      if (k == v.rst_at)   rst   = 1'b1;
      if (k == v.start_at) start = 1'b1;
      @(negedge clk);
      compare_pop();
      @(posedge clk); #1;
      stop = 1'b0; rst = 1'b0; start = 1'b0;
    end
    led_prev = e.led;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{dir:0, loop:0, period:3, ncyc:643, stop_at:-1,  rst_at:-1,  start_at:-1, mutate:0};
    vt[1] = '{dir:1, loop:1, period:0, ncyc:302, stop_at:300, rst_at:-1,  start_at:-1, mutate:0};
    vt[2] = '{dir:0, loop:0, period:1, ncyc:154, stop_at:151, rst_at:-1,  start_at:-1, mutate:0};
    vt[3] = '{dir:0, loop:0, period:2, ncyc:515, stop_at:-1,  rst_at:-1,  start_at:42, mutate:0};
    vt[4] = '{dir:1, loop:0, period:5, ncyc:899, stop_at:-1,  rst_at:-1,  start_at:-1, mutate:1};
    vt[5] = '{dir:0, loop:0, period:4, ncyc:125, stop_at:-1,  rst_at:122, start_at:-1, mutate:0};
    vt[6] = '{dir:0, loop:1, period:1, ncyc:40,  stop_at:37,  rst_at:-1,  start_at:-1, mutate:0};

    rst = 1'b1; start = 1'b1; stop = 1'b0; dir = 1'b1; loop = 1'b1; period = 16'd9;
    // Reset held two cycles, overriding a pending start.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    cur_run = -1;
    sb.push_back('{addr: 7'd0, led: 7'h7F, busy: 1'b0, done: 1'b0, chk_addr: 1'b1});
    compare_pop();
    rst = 1'b0; start = 1'b0;
    led_prev = 7'h7F;

    // start together with stop in IDLE must not launch a run.
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cur_k = k;
      sb.push_back('{addr: 7'd0, led: 7'h7F, busy: 1'b0, done: 1'b0, chk_addr: 1'b1});
      @(posedge clk); #1;
      @(negedge clk);
      compare_pop();
    end
    start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      cur_run = i;
      run(vt[i]);
      if (vt[i].rst_at >= 0) led_prev = 7'h7F;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
